// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit
// Decode stage control for a five-stage MIPS-like pipeline. It decodes the
// IF/ID instruction into registered ID/EX controls, detects load-use hazards,
// squashes on taken branches and sequences a STOP instruction into a halt.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   instr, instr_valid IF/ID instruction word and its valid flag
//   branch_taken       EX resolved a taken branch this cycle
//   ex_*               registered ID/EX control fields
//   ex_valid           ID/EX slot holds a real instruction
//   pc_stall           combinational; hold PC and IF/ID
//   ifid_flush         combinational; squash IF/ID
//   illegal_instr      registered one-cycle pulse on unsupported encodings
//   halted             registered; processor stopped until reset
module pipe_ctrl_unit #(
   parameter int ALUCTRL_W    = 4,
   parameter int ALUSRC_W     = 3,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          instr,
   input  logic                 instr_valid,
   input  logic                 branch_taken,
   output logic                 ex_reg_write,
   output logic                 ex_mem2reg,
   output logic                 ex_mem_write,
   output logic                 ex_beq,
   output logic                 ex_bne,
   output logic                 ex_reg_dst,
   output logic [ALUCTRL_W-1:0] ex_alu_ctrl,
   output logic [ALUSRC_W-1:0]  ex_alu_src,
   output logic [4:0]           ex_rd,
   output logic                 ex_valid,
   output logic                 pc_stall,
   output logic                 ifid_flush,
   output logic                 illegal_instr,
   output logic                 halted
);

   typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

   state_t state, state_next;
   logic [3:0] count, count_next;

   logic [5:0] opcode, func;
   logic [4:0] rs, rt, rd;

   logic                 d_reg_write, d_mem2reg, d_mem_write, d_beq, d_bne, d_reg_dst;
   logic [ALUCTRL_W-1:0] d_alu_ctrl;
   logic [ALUSRC_W-1:0]  d_alu_src;
   logic [4:0]           d_rd;
   logic                 d_legal, d_stop, d_reads_rt;

   logic load_use, issue, illegal_next;

   assign opcode = instr[31:26];
   assign func   = instr[5:0];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];
   assign rd     = instr[15:11];

   // Instruction decode. Anything not explicitly recognised leaves d_legal
   // low and is turned into a bubble plus an illegal pulse downstream.
   always_comb begin
      d_reg_write = 1'b0;
      d_mem2reg   = 1'b0;
      d_mem_write = 1'b0;
      d_beq       = 1'b0;
      d_bne       = 1'b0;
      d_reg_dst   = 1'b0;
      d_alu_ctrl  = '0;
      d_alu_src   = '0;
      d_rd        = 5'd0;
      d_legal     = 1'b0;
      d_stop      = 1'b0;
      d_reads_rt  = 1'b0;
      case (opcode)
         6'd0: begin
            d_reads_rt  = 1'b1;
            d_legal     = 1'b1;
            d_reg_write = 1'b1;
            d_reg_dst   = 1'b1;
            d_rd        = rd;
            case (func)
               6'd0:          begin d_alu_ctrl = ALUCTRL_W'(7); d_alu_src = ALUSRC_W'(4); end
               6'd2:          begin d_alu_ctrl = ALUCTRL_W'(8); d_alu_src = ALUSRC_W'(4); end
               6'd3:          begin d_alu_ctrl = ALUCTRL_W'(9); d_alu_src = ALUSRC_W'(4); end
               6'd4:          begin d_alu_ctrl = ALUCTRL_W'(7); d_alu_src = ALUSRC_W'(3); end
               6'd6:          begin d_alu_ctrl = ALUCTRL_W'(8); d_alu_src = ALUSRC_W'(3); end
               6'd7:          begin d_alu_ctrl = ALUCTRL_W'(9); d_alu_src = ALUSRC_W'(3); end
               6'd32, 6'd33:  d_alu_ctrl = ALUCTRL_W'(0);
               6'd34, 6'd35:  d_alu_ctrl = ALUCTRL_W'(1);
               6'd36:         d_alu_ctrl = ALUCTRL_W'(2);
               6'd37:         d_alu_ctrl = ALUCTRL_W'(3);
               6'd38:         d_alu_ctrl = ALUCTRL_W'(4);
               6'd39:         d_alu_ctrl = ALUCTRL_W'(5);
               6'd42:         d_alu_ctrl = ALUCTRL_W'(6);
               default: begin
                  d_legal     = 1'b0;
                  d_reg_write = 1'b0;
                  d_reg_dst   = 1'b0;
                  d_rd        = 5'd0;
               end
            endcase
         end
         6'd8, 6'd9: begin
            d_legal = 1'b1; d_reg_write = 1'b1; d_rd = rt;
            d_alu_ctrl = ALUCTRL_W'(0); d_alu_src = ALUSRC_W'(1);
         end
         6'd12: begin
            d_legal = 1'b1; d_reg_write = 1'b1; d_rd = rt;
            d_alu_ctrl = ALUCTRL_W'(2); d_alu_src = ALUSRC_W'(2);
         end
         6'd13: begin
            d_legal = 1'b1; d_reg_write = 1'b1; d_rd = rt;
            d_alu_ctrl = ALUCTRL_W'(3); d_alu_src = ALUSRC_W'(2);
         end
         6'd14: begin
            d_legal = 1'b1; d_reg_write = 1'b1; d_rd = rt;
            d_alu_ctrl = ALUCTRL_W'(4); d_alu_src = ALUSRC_W'(2);
         end
         6'd35: begin
            d_legal = 1'b1; d_reg_write = 1'b1; d_mem2reg = 1'b1; d_rd = rt;
            d_alu_ctrl = ALUCTRL_W'(0); d_alu_src = ALUSRC_W'(1);
         end
         6'd43: begin
            d_legal = 1'b1; d_mem_write = 1'b1; d_reads_rt = 1'b1;
            d_alu_ctrl = ALUCTRL_W'(0); d_alu_src = ALUSRC_W'(1);
         end
         6'd4: begin
            d_legal = 1'b1; d_beq = 1'b1; d_reads_rt = 1'b1;
            d_alu_ctrl = ALUCTRL_W'(1);
         end
         6'd5: begin
            d_legal = 1'b1; d_bne = 1'b1; d_reads_rt = 1'b1;
            d_alu_ctrl = ALUCTRL_W'(1);
         end
         6'd63: d_stop = 1'b1;
         default: ;
      endcase
   end

   // A load writing a non-zero register that the ID instruction sources must
   // wait one cycle; the bubble it inserts clears ex_valid so the hazard
   // cannot re-trigger on the following cycle.
   assign load_use = instr_valid & ex_valid & ex_mem2reg & (ex_rd != 5'd0) &
                     ((ex_rd == rs) | ((ex_rd == rt) & d_reads_rt));

   // Next-state and hazard control. A taken branch outranks the load-use
   // stall and STOP decode while running; once draining or halted the PC is
   // frozen and only bubbles issue. Stall and flush are masked during reset.
   always_comb begin
      state_next   = state;
      count_next   = count;
      pc_stall     = 1'b0;
      ifid_flush   = 1'b0;
      issue        = 1'b0;
      illegal_next = 1'b0;
      case (state)
         RUN: begin
            if (branch_taken) begin
               ifid_flush = 1'b1;
            end else if (load_use) begin
               pc_stall = 1'b1;
            end else if (instr_valid) begin
               if (d_stop) begin
                  state_next = DRAIN;
                  count_next = DRAIN_LOAD;
               end else if (d_legal) begin
                  issue = 1'b1;
               end else begin
                  illegal_next = 1'b1;
               end
            end
         end
         DRAIN: begin
            pc_stall = 1'b1;
            if (count == 4'd0) begin
               state_next = HALT;
            end else begin
               count_next = count - 4'd1;
            end
         end
         HALT: begin
            pc_stall = 1'b1;
         end
         default: state_next = RUN;
      endcase
      if (rst) begin
         pc_stall   = 1'b0;
         ifid_flush = 1'b0;
      end
   end

   // ID/EX register, FSM state and status flags. Every cycle either a
   // decoded instruction or a bubble is loaded.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= RUN;
         count         <= 4'd0;
         halted        <= 1'b0;
         illegal_instr <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_mem2reg    <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_beq        <= 1'b0;
         ex_bne        <= 1'b0;
         ex_reg_dst    <= 1'b0;
         ex_alu_ctrl   <= '0;
         ex_alu_src    <= '0;
         ex_rd         <= 5'd0;
         ex_valid      <= 1'b0;
      end else begin
         state         <= state_next;
         count         <= count_next;
         halted        <= (state_next == HALT);
         illegal_instr <= illegal_next;
         ex_reg_write  <= issue & d_reg_write;
         ex_mem2reg    <= issue & d_mem2reg;
         ex_mem_write  <= issue & d_mem_write;
         ex_beq        <= issue & d_beq;
         ex_bne        <= issue & d_bne;
         ex_reg_dst    <= issue & d_reg_dst;
         ex_alu_ctrl   <= issue ? d_alu_ctrl : '0;
         ex_alu_src    <= issue ? d_alu_src : '0;
         ex_rd         <= issue ? d_rd : 5'd0;
         ex_valid      <= issue;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit
// Table-driven decode vectors followed by hand-written sequences for
// reset, load-use, branch flush, STOP drain/halt and illegal pulses.
module tb_pipe_ctrl_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        instr_valid;
   logic        branch_taken;
   logic        ex_reg_write, ex_mem2reg, ex_mem_write, ex_beq, ex_bne, ex_reg_dst;
   logic [3:0]  ex_alu_ctrl;
   logic [2:0]  ex_alu_src;
   logic [4:0]  ex_rd;
   logic        ex_valid, pc_stall, ifid_flush, illegal_instr, halted;

   int checks   = 0;
   int failures = 0;

   pipe_ctrl_unit #(.ALUCTRL_W(4), .ALUSRC_W(3), .DRAIN_CYCLES(3)) dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .branch_taken(branch_taken),
      .ex_reg_write(ex_reg_write), .ex_mem2reg(ex_mem2reg), .ex_mem_write(ex_mem_write),
      .ex_beq(ex_beq), .ex_bne(ex_bne), .ex_reg_dst(ex_reg_dst),
      .ex_alu_ctrl(ex_alu_ctrl), .ex_alu_src(ex_alu_src), .ex_rd(ex_rd),
      .ex_valid(ex_valid), .pc_stall(pc_stall), .ifid_flush(ifid_flush),
      .illegal_instr(illegal_instr), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic        valid;
      logic        bt;
      logic [1:0]  comb;   // {pc_stall, ifid_flush} before the edge
      logic [5:0]  ctl;    // {reg_write, mem2reg, mem_write, beq, bne, reg_dst}
      logic [3:0]  alu;
      logic [2:0]  src;
      logic [4:0]  rd;
      logic        v;
      logic        ill;
   } vec_t;

   vec_t vecs[24];

   localparam logic [31:0] STOP = 32'hFC000000;

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
      return {6'd0, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // Drive new ID inputs away from the active edge and let them settle.
   task automatic applyStimulus(input logic [31:0] i, input logic v, input logic b);
      @(negedge clk);
      instr        = i;
      instr_valid  = v;
      branch_taken = b;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   function automatic logic [31:0] exBundle();
      return {9'd0, ex_reg_write, ex_mem2reg, ex_mem_write, ex_beq, ex_bne, ex_reg_dst,
              ex_alu_ctrl, ex_alu_src, ex_rd, ex_valid, illegal_instr};
   endfunction

   function automatic logic [31:0] expBundle(input vec_t e);
      return {9'd0, e.ctl, e.alu, e.src, e.rd, e.v, e.ill};
   endfunction

   initial begin
      vecs[0]  = '{32'h00221820,                 1, 0, 2'b00, 6'b100001, 0, 0, 3,  1, 0};
      vecs[1]  = '{rtype(1, 2, 4, 0, 34),        1, 0, 2'b00, 6'b100001, 1, 0, 4,  1, 0};
      vecs[2]  = '{rtype(1, 2, 8, 0, 36),        1, 0, 2'b00, 6'b100001, 2, 0, 8,  1, 0};
      vecs[3]  = '{rtype(1, 2, 9, 0, 37),        1, 0, 2'b00, 6'b100001, 3, 0, 9,  1, 0};
      vecs[4]  = '{rtype(1, 2, 10, 0, 38),       1, 0, 2'b00, 6'b100001, 4, 0, 10, 1, 0};
      vecs[5]  = '{rtype(1, 2, 11, 0, 39),       1, 0, 2'b00, 6'b100001, 5, 0, 11, 1, 0};
      vecs[6]  = '{rtype(1, 2, 12, 0, 42),       1, 0, 2'b00, 6'b100001, 6, 0, 12, 1, 0};
      vecs[7]  = '{rtype(0, 2, 13, 5, 0),        1, 0, 2'b00, 6'b100001, 7, 4, 13, 1, 0};
      vecs[8]  = '{rtype(0, 2, 14, 5, 2),        1, 0, 2'b00, 6'b100001, 8, 4, 14, 1, 0};
      vecs[9]  = '{rtype(0, 2, 15, 5, 3),        1, 0, 2'b00, 6'b100001, 9, 4, 15, 1, 0};
      vecs[10] = '{rtype(1, 2, 16, 0, 4),        1, 0, 2'b00, 6'b100001, 7, 3, 16, 1, 0};
      vecs[11] = '{rtype(1, 2, 17, 0, 7),        1, 0, 2'b00, 6'b100001, 9, 3, 17, 1, 0};
      vecs[12] = '{rtype(1, 2, 18, 0, 33),       1, 0, 2'b00, 6'b100001, 0, 0, 18, 1, 0};
      vecs[13] = '{itype(8, 1, 7, 16'hFFF0),     1, 0, 2'b00, 6'b100000, 0, 1, 7,  1, 0};
      vecs[14] = '{itype(13, 1, 20, 16'h00FF),   1, 0, 2'b00, 6'b100000, 3, 2, 20, 1, 0};
      vecs[15] = '{itype(35, 1, 21, 16'd4),      1, 0, 2'b00, 6'b110000, 0, 1, 21, 1, 0};
      vecs[16] = '{itype(43, 1, 22, 16'd8),      1, 0, 2'b00, 6'b001000, 0, 1, 0,  1, 0};
      vecs[17] = '{itype(4, 1, 2, 16'd3),        1, 0, 2'b00, 6'b000100, 1, 0, 0,  1, 0};
      vecs[18] = '{itype(5, 1, 2, 16'd3),        1, 0, 2'b00, 6'b000010, 1, 0, 0,  1, 0};
      vecs[19] = '{itype(2, 0, 0, 16'd0),        1, 0, 2'b00, 6'b000000, 0, 0, 0,  0, 1};
      vecs[20] = '{rtype(31, 0, 0, 0, 8),        1, 0, 2'b00, 6'b000000, 0, 0, 0,  0, 1};
      vecs[21] = '{32'h00221820,                 0, 0, 2'b00, 6'b000000, 0, 0, 0,  0, 0};
      vecs[22] = '{32'h00221820,                 1, 1, 2'b01, 6'b000000, 0, 0, 0,  0, 0};
      vecs[23] = '{itype(12, 3, 23, 16'h0F0F),   1, 0, 2'b00, 6'b100000, 2, 2, 23, 1, 0};

      // Reset: stall and flush stay low even with a branch presented.
      rst = 1'b1;
      applyStimulus(itype(35, 1, 5, 16'd0), 1, 1);
      checkOutput("reset_comb", {30'd0, pc_stall, ifid_flush}, 0);
      tick();
      tick();
      checkOutput("reset_ex", exBundle(), 0);
      checkOutput("reset_halted", {31'd0, halted}, 0);
      @(negedge clk);
      rst = 1'b0;

      // Table: each vector followed by a bubble cycle so no hazard carries over.
      for (int k = 0; k < 24; k++) begin
         applyStimulus(vecs[k].instr, vecs[k].valid, vecs[k].bt);
         checkOutput($sformatf("vec%0d_comb", k), {30'd0, pc_stall, ifid_flush}, {30'd0, vecs[k].comb});
         tick();
         checkOutput($sformatf("vec%0d_ex", k), exBundle(), expBundle(vecs[k]));
         applyStimulus(32'd0, 0, 0);
         tick();
         checkOutput($sformatf("vec%0d_gap", k), {30'd0, ex_valid, illegal_instr}, 0);
      end

      // Load-use: lw $5 then add $6,$5,$2 -> one stall, one bubble, then add.
      applyStimulus(itype(35, 1, 5, 16'd0), 1, 0);
      tick();
      applyStimulus(rtype(5, 2, 6, 0, 32), 1, 0);
      checkOutput("lu_stall", {30'd0, pc_stall, ifid_flush}, 32'b10);
      tick();
      checkOutput("lu_bubble", {31'd0, ex_valid}, 0);
      #3;
      checkOutput("lu_release", {30'd0, pc_stall, ifid_flush}, 0);
      tick();
      checkOutput("lu_issue", {26'd0, ex_valid, ex_rd}, {26'd0, 1'b1, 5'd6});

      // Load-use through rt on an R-type source.
      applyStimulus(itype(35, 1, 9, 16'd0), 1, 0);
      tick();
      applyStimulus(rtype(2, 9, 10, 0, 32), 1, 0);
      checkOutput("lu_rt_stall", {31'd0, pc_stall}, 1);
      tick();
      applyStimulus(32'd0, 0, 0);
      tick();

      // Load into $0 never stalls.
      applyStimulus(itype(35, 1, 0, 16'd0), 1, 0);
      tick();
      applyStimulus(rtype(0, 2, 6, 0, 32), 1, 0);
      checkOutput("lu_zero_nostall", {31'd0, pc_stall}, 0);
      tick();
      checkOutput("lu_zero_issue", {26'd0, ex_valid, ex_rd}, {26'd0, 1'b1, 5'd6});

      // Branch taken beats load-use.
      applyStimulus(itype(35, 1, 5, 16'd0), 1, 0);
      tick();
      applyStimulus(rtype(5, 2, 6, 0, 32), 1, 1);
      checkOutput("br_over_lu", {30'd0, pc_stall, ifid_flush}, 32'b01);
      tick();
      checkOutput("br_bubble", {31'd0, ex_valid}, 0);

      // STOP squashed by a taken branch: no drain follows.
      applyStimulus(STOP, 1, 1);
      checkOutput("stop_flush_comb", {30'd0, pc_stall, ifid_flush}, 32'b01);
      tick();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(32'd0, 0, 0);
         checkOutput($sformatf("stop_flush_run%0d", k), {30'd0, pc_stall, halted}, 0);
         tick();
      end

      // STOP drain: stall from the next cycle, halt three edges after STOP leaves ID.
      applyStimulus(STOP, 1, 0);
      checkOutput("stop_comb", {30'd0, pc_stall, ifid_flush}, 0);
      tick();
      checkOutput("stop_bubble", {30'd0, ex_valid, halted}, 0);
      applyStimulus(32'h00221820, 1, 1);
      checkOutput("drain_stall_noflush", {30'd0, pc_stall, ifid_flush}, 32'b10);
      tick();
      checkOutput("drain1", {30'd0, ex_valid, halted}, 0);
      applyStimulus(32'h00221820, 1, 0);
      tick();
      checkOutput("drain2", {30'd0, ex_valid, halted}, 0);
      applyStimulus(32'h00221820, 1, 0);
      tick();
      checkOutput("halt_set", {30'd0, ex_valid, halted}, 32'b01);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(32'h00221820, 1, 0);
         checkOutput($sformatf("halt_hold%0d", k), {29'd0, pc_stall, ex_valid, halted}, 32'b101);
         tick();
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("halt_reset_comb", {30'd0, pc_stall, ifid_flush}, 0);
      tick();
      checkOutput("halt_reset", {31'd0, halted}, 0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(32'h00221820, 1, 0);
      checkOutput("post_reset_run", {31'd0, pc_stall}, 0);
      tick();
      checkOutput("post_reset_issue", {26'd0, ex_valid, ex_rd}, {26'd0, 1'b1, 5'd3});

      // Reset in the middle of a drain returns to RUN.
      applyStimulus(STOP, 1, 0);
      tick();
      applyStimulus(32'd0, 0, 0);
      tick();
      @(negedge clk);
      rst = 1'b1;
      tick();
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(32'h00221820, 1, 0);
      checkOutput("mid_drain_reset", {30'd0, pc_stall, halted}, 0);
      tick();
      tick();
      tick();
      checkOutput("mid_drain_no_halt", {31'd0, halted}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 The block SHALL have parameter ALUCTRL_W, default 4, ALU operation code width.
REQ-002 The block SHALL have parameter ALUSRC_W, default 3, ALU operand-select width.
REQ-003 The block SHALL have parameter DRAIN_CYCLES, default 3, cycles between STOP leaving ID and halt; legal range 1..15.
REQ-004 Ports (name direction width meaning) SHALL be:
 clk  in  1  single clock; all state on rising edge
 rst  in  1  synchronous, active-high reset
 instr  in  32  IF/ID instruction word
 instr_valid  in  1  IF/ID holds a real instruction
 branch_taken  in  1  EX resolved a taken branch this cycle
 ex_reg_write, ex_mem2reg, ex_mem_write, ex_beq, ex_bne, ex_reg_dst  out  1 each  registered ID/EX controls
 ex_alu_ctrl  out  ALUCTRL_W  registered ALU op
 ex_alu_src  out  ALUSRC_W  registered operand select
 ex_rd  out  5  registered write-back register index
 ex_valid  out  1  ID/EX slot holds a real instruction
 pc_stall  out  1  combinational; hold PC and IF/ID
 ifid_flush  out  1  combinational; squash IF/ID
 illegal_instr  out  1  registered one-cycle pulse, unsupported opcode/func
 halted  out  1  registered; processor stopped

Function
REQ-005 Decode SHALL use opcode=instr[31:26], func=instr[5:0], rs=[25:21], rt=[20:16], rd=[15:11].
REQ-006 ALU codes: 0 add,1 sub,2 and,3 or,4 xor,5 nor,6 slt,7 sll,8 srl,9 sra; ALU src: 0 rt,1 sign-ext imm,2 zero-ext imm,3 rs-as-shift-amount,4 shamt.
REQ-007 R-type (opcode 0): func 0/2/3 -> ALU 7/8/9 src 4; func 4/6/7 -> ALU 7/8/9 src 3; func 32/33 add, 34/35 sub, 36 and, 37 or, 38 xor, 39 nor, 42 slt, src 0; all R-type reg_write=1, reg_dst=1, ex_rd=rd.
REQ-008 I-type: addi(8)/addiu(9) add src1; andi(12)/ori(13)/xori(14) and/or/xor src2; all reg_write=1, reg_dst=0, ex_rd=rt.
REQ-009 lw(35): reg_write=1, mem2reg=1, add, src1, ex_rd=rt; sw(43): mem_write=1, add, src1, reg_write=0.
REQ-010 beq(4)/bne(5): beq/bne=1 respectively, ALU sub, src0, reg_write=0.
REQ-011 STOP opcode 63 SHALL issue as bubble and start drain (REQ-016).
REQ-012 Any other opcode/func (incl. jr, j, jal) SHALL issue a bubble and pulse illegal_instr for one cycle.
REQ-013 Bubble = all ex_* controls 0, ex_rd 0, ex_valid 0; also loaded when instr_valid=0.
REQ-014 Load-use: if ex_valid & ex_mem2reg & ex_rd!=0 & (ex_rd==rs | (ex_rd==rt & ID instruction reads rt: R-type, beq, bne, sw)) and instr_valid, pc_stall=1 and a bubble SHALL be loaded; exactly one bubble per hazard.
REQ-015 branch_taken=1 SHALL force ifid_flush=1 and a bubble into ID/EX, overriding load-use stall (pc_stall=0) and STOP decode.
REQ-016 FSM states RUN, DRAIN, HALT. RUN->DRAIN on valid, unflushed, unstalled STOP in ID; counter loads DRAIN_CYCLES-1. DRAIN: pc_stall=1, bubbles, branch_taken ignored, counter decrements; at 0 -> HALT. HALT: pc_stall=1, bubbles, halted=1 until rst.
REQ-017 Latency: decode-to-ex_* exactly one cycle.

Reset
REQ-018 While rst=1 at a clock edge: state RUN, counter 0, all ex_* outputs 0, illegal_instr 0, halted 0; rst mid-DRAIN or in HALT SHALL return to RUN next cycle.
REQ-019 pc_stall and ifid_flush SHALL be 0 during the reset cycle.

Verification
REQ-020 add $3,$1,$2 (0x00221820) valid -> next cycle ex_reg_write=1, ex_alu_ctrl=0, ex_alu_src=0, ex_reg_dst=1, ex_rd=3, ex_valid=1.
REQ-021 lw $5,0($1) then add $6,$5,$2 -> pc_stall=1 one cycle, one bubble (ex_valid=0), then add issues with ex_rd=6.
REQ-022 lw $0 then use $0 -> no stall; lw $5 with branch_taken same cycle as dependent add -> ifid_flush=1, pc_stall=0, bubble.
REQ-023 STOP (0xFC000000) with DRAIN_CYCLES=3 -> pc_stall=1 from next cycle, halted=1 exactly 3 cycles after STOP leaves ID, held; rst -> halted=0.
REQ-024 opcode 0x3F with branch_taken=1 -> flushed, no drain; opcode 0x02 (j) -> bubble, illegal_instr=1 one cycle.
